// File: rtl/uart_pkg.sv
// Shared UART receive-side types: character width and the FIFO entry layout.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   // One received character plus the framing-error flag reported with it.
   typedef struct packed {
      logic                   err;
      logic [UART_DATA_W-1:0] data;
   } uart_rx_entry_t;

endpackage

// File: rtl/sync_rise_detect.sv
// Three-flop synchroniser for a slow strobe from another clock domain, with a
// single-cycle pulse on each rising edge of the synchronised level.
module sync_rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_pulse
);

   logic r_s1;
   logic r_s2;
   logic r_s3;

   // Shift chain: s1/s2 resolve metastability, s3 holds the previous level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= i_async;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   // A held-high level gives one pulse only; s3 starting at 0 after reset
   // means a level already high at release still yields exactly one pulse.
   assign o_pulse = r_s2 & ~r_s3;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: captures each byte on the done
// strobe, queues it in a first-word-fall-through FIFO, and keeps status and
// sticky error flags for the bus side.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = UART_DATA_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rx_done,
   input  logic [DATA_W-1:0]      rx_data,
   input  logic                   rx_err,
   input  logic                   rd_en,
   input  logic                   flush,
   input  logic                   clr_flags,
   output logic [DATA_W-1:0]      rd_data,
   output logic                   rd_err,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overrun,
   output logic                   err_seen
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;
   logic           r_overrun;
   logic           r_err_seen;
   uart_rx_entry_t r_mem [DEPTH];

   logic           w_push;
   logic           w_pop;
   logic           w_full;
   logic           w_accept;
   logic           w_set_ovr;
   logic           w_set_err;
   uart_rx_entry_t w_wr_entry;
   uart_rx_entry_t w_head;

   sync_rise_detect u_done_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (rx_done),
      .o_pulse (w_push)
   );

   // A pop is only honoured when an entry is already visible, so a push into
   // an empty FIFO never gets consumed in the same cycle it lands.
   assign w_full     = (r_count == CW'(DEPTH));
   assign w_pop      = rd_en & (r_count != '0) & ~flush;
   // When full, a simultaneous pop frees the head slot, which the write reuses.
   assign w_accept   = w_push & (~w_full | w_pop) & ~flush;
   assign w_set_ovr  = w_push & w_full & ~w_pop & ~flush;
   assign w_set_err  = w_accept & rx_err;

   assign w_wr_entry.err  = rx_err;
   assign w_wr_entry.data = rx_data;

   // Flop storage, one always block per entry so each slot has its own enable.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic w_we;
         assign w_we = w_accept & (r_wr_ptr == AW'(gi));

         // Capture the incoming entry when this slot is the write target.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_mem[gi] <= '0;
            end else if (w_we) begin
               r_mem[gi] <= w_wr_entry;
            end
         end
      end
   endgenerate

   // Pointers wrap at DEPTH on their own; flush rewinds both to the origin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Occupancy: +1 on a lone write, -1 on a lone read, unchanged on both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (flush) begin
         r_count <= '0;
      end else if (w_accept && !w_pop) begin
         r_count <= r_count + 1'b1;
      end else if (w_pop && !w_accept) begin
         r_count <= r_count - 1'b1;
      end
   end

   // Sticky flags: a new set event in the same cycle beats clr_flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overrun  <= 1'b0;
         r_err_seen <= 1'b0;
      end else begin
         if (w_set_ovr)      r_overrun <= 1'b1;
         else if (clr_flags) r_overrun <= 1'b0;
         if (w_set_err)      r_err_seen <= 1'b1;
         else if (clr_flags) r_err_seen <= 1'b0;
      end
   end

   assign w_head   = r_mem[r_rd_ptr];
   assign rd_data  = w_head.data;
   assign rd_err   = w_head.err;
   assign empty    = (r_count == '0);
   assign full     = w_full;
   assign count    = r_count;
   assign overrun  = r_overrun;
   assign err_seen = r_err_seen;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a queue-based model of the receive buffer
// is checked against the DUT every cycle, plus literal checks per scenario.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_done;
   logic [7:0] rx_data;
   logic       rx_err;
   logic       rd_en;
   logic       flush;
   logic       clr_flags;
   logic [7:0] rd_data;
   logic       rd_err;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overrun;
   logic       err_seen;

   int n_checks = 0;
   int n_pass   = 0;

   uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_done   (rx_done),
      .rx_data   (rx_data),
      .rx_err    (rx_err),
      .rd_en     (rd_en),
      .flush     (flush),
      .clr_flags (clr_flags),
      .rd_data   (rd_data),
      .rd_err    (rd_err),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .overrun   (overrun),
      .err_seen  (err_seen)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Entries are {err,data}. A rise of rx_done seen at edge n is stored at
   // edge n+2 (sampled at E1, stored at E3).
   logic [8:0] m_q[$];
   bit m_ovr, m_err;
   bit m_d1, m_d2, m_d3;   // rx_done as sampled 1,2,3 edges ago
   bit m_push, m_pop, m_set_o, m_set_e;
   int m_sz;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_ovr = 0; m_err = 0;
         m_d1 = 0; m_d2 = 0; m_d3 = 0;
      end else begin
         m_push = m_d2 & ~m_d3;
         m_d3 = m_d2; m_d2 = m_d1; m_d1 = rx_done;
         m_sz = m_q.size();
         m_set_o = 0; m_set_e = 0;
         if (flush) begin
            m_q.delete();
         end else begin
            m_pop = rd_en && (m_sz > 0);
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
               if (m_sz < DEPTH || m_pop) begin
                  m_q.push_back({rx_err, rx_data});
                  m_set_e = rx_err;
               end else begin
                  m_set_o = 1;
               end
            end
         end
         m_ovr = m_set_o ? 1'b1 : (clr_flags ? 1'b0 : m_ovr);
         m_err = m_set_e ? 1'b1 : (clr_flags ? 1'b0 : m_err);
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_count", count, m_q.size());
         chk("m_empty", empty, m_q.size() == 0);
         chk("m_full", full, m_q.size() == DEPTH);
         chk("m_overrun", overrun, m_ovr);
         chk("m_err_seen", err_seen, m_err);
         if (m_q.size() > 0) begin
            chk("m_rd_data", rd_data, m_q[0][7:0]);
            chk("m_rd_err", rd_err, m_q[0][8]);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_frame(input logic [7:0] d, input logic e, input bit pop_at_push);
      @(negedge clk); #1;
      rx_data = d; rx_err = e; rx_done = 1'b1;
      @(negedge clk);
      @(negedge clk);
      if (pop_at_push) begin #1; rd_en = 1'b1; end
      @(negedge clk); #1;
      rd_en = 1'b0; rx_done = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse(input bit rd, input bit fl, input bit clr);
      @(negedge clk); #1;
      rd_en = rd; flush = fl; clr_flags = clr;
      @(negedge clk); #1;
      rd_en = 0; flush = 0; clr_flags = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0; rx_done = 1; rx_data = 8'h99; rx_err = 0;
      rd_en = 0; flush = 0; clr_flags = 0;

      // 1: reset with rx_done held high
      repeat (3) @(negedge clk);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_err", rd_err, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_err_seen", err_seen, 0);
      #1 rst_n = 1;
      repeat (6) @(negedge clk);
      chk("t1_count_one", count, 1);
      chk("t1_head", rd_data, 8'h99);
      repeat (6) @(negedge clk);
      chk("t1_still_one", count, 1);
      #1 rx_done = 0;
      pulse(1, 0, 0);
      chk("t1_drained", count, 0);
      $display("t1 reset-held done: count=%0d", count);

      // 2: three frames, read back in order
      for (int i = 0; i < 3; i++) begin
         send_frame(8'h41 + 8'(i), 0, 0);
         chk("t2_not_empty", empty, 0);
         $display("t2 push 0x%02h count=%0d", 8'h41 + 8'(i), count);
      end
      chk("t2_head0", rd_data, 8'h41);
      pulse(1, 0, 0);
      chk("t2_head1", rd_data, 8'h42);
      pulse(1, 0, 0);
      chk("t2_head2", rd_data, 8'h43);
      pulse(1, 0, 0);
      chk("t2_empty", empty, 1);
      chk("t2_count0", count, 0);

      // 3: overfill by two
      for (int i = 0; i < DEPTH + 2; i++) begin
         send_frame(8'h60 + 8'(i), 0, 0);
         $display("t3 push 0x%02h count=%0d overrun=%0d", 8'h60 + 8'(i), count, overrun);
      end
      chk("t3_full", full, 1);
      chk("t3_count16", count, 16);
      chk("t3_overrun", overrun, 1);
      chk("t3_head", rd_data, 8'h60);

      // 4: push and pop together while full
      pulse(0, 0, 1);
      chk("t4_ovr_clr", overrun, 0);
      send_frame(8'hA5, 0, 1);
      chk("t4_count16", count, 16);
      chk("t4_ovr_zero", overrun, 0);
      for (int i = 0; i < DEPTH; i++) begin
         logic [7:0] exp_b;
         exp_b = (i < DEPTH - 1) ? 8'h61 + 8'(i) : 8'hA5;
         chk("t4_drain", rd_data, exp_b);
         $display("t4 pop 0x%02h", rd_data);
         pulse(1, 0, 0);
      end
      chk("t4_empty", empty, 1);

      // 5: framing error frame
      send_frame(8'h55, 1, 0);
      chk("t5_rd_err", rd_err, 1);
      chk("t5_err_seen", err_seen, 1);
      chk("t5_data", rd_data, 8'h55);
      pulse(0, 0, 1);
      chk("t5_err_clr", err_seen, 0);
      pulse(1, 0, 0);
      pulse(1, 0, 0);
      chk("t5_count0", count, 0);
      $display("t5 error frame done: err_seen=%0d", err_seen);

      // 6: flush with rd_en
      for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 0, 0);
      chk("t6_count5", count, 5);
      pulse(1, 1, 0);
      chk("t6_count0", count, 0);
      chk("t6_empty", empty, 1);
      chk("t6_overrun", overrun, 0);
      repeat (4) @(negedge clk);
      chk("t6_no_spurious", count, 0);
      send_frame(8'h3C, 0, 0);
      chk("t6_head", rd_data, 8'h3C);
      chk("t6_count1", count, 1);
      $display("t6 flush done: head=0x%02h", rd_data);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
